// File: rtl/decode_pkg.sv
// Shared record type, opcode-class indices and funct3/funct7 legality tables for the RV32 decode stage.
// Define INST_DECODE_MEXT_EN to accept M-extension OP instructions (funct7 0x01).
package decode_pkg;

`ifdef INST_DECODE_MEXT_EN
  localparam logic MEXT_EN = 1'b1;
`else
  localparam logic MEXT_EN = 1'b0;
`endif

  localparam int OPC_NUM = 11;

  // Bit positions inside the one-hot opcode-class vector
  typedef enum logic [3:0] {
    OPC_LOAD    = 4'd0,
    OPC_MISCMEM = 4'd1,
    OPC_OPIMM   = 4'd2,
    OPC_AUIPC   = 4'd3,
    OPC_STORE   = 4'd4,
    OPC_OP      = 4'd5,
    OPC_LUI     = 4'd6,
    OPC_BRANCH  = 4'd7,
    OPC_JALR    = 4'd8,
    OPC_JAL     = 4'd9,
    OPC_SYSTEM  = 4'd10
  } opc_idx_e;

  localparam logic [4:0] OPV_LOAD    = 5'b00000;
  localparam logic [4:0] OPV_MISCMEM = 5'b00011;
  localparam logic [4:0] OPV_OPIMM   = 5'b00100;
  localparam logic [4:0] OPV_AUIPC   = 5'b00101;
  localparam logic [4:0] OPV_STORE   = 5'b01000;
  localparam logic [4:0] OPV_OP      = 5'b01100;
  localparam logic [4:0] OPV_LUI     = 5'b01101;
  localparam logic [4:0] OPV_BRANCH  = 5'b11000;
  localparam logic [4:0] OPV_JALR    = 5'b11001;
  localparam logic [4:0] OPV_JAL     = 5'b11011;
  localparam logic [4:0] OPV_SYSTEM  = 5'b11100;

  localparam logic [6:0] F7_ZERO   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  // Bit n set means funct3 == n is legal for that class
  localparam logic [7:0] LOAD_F3_OK   = 8'b0011_0111;
  localparam logic [7:0] BRANCH_F3_OK = 8'b1111_0011;
  localparam logic [7:0] STORE_F3_OK  = 8'b0000_0111;
  localparam logic [7:0] CSR_F3_OK    = 8'b1110_1110;

  typedef struct packed {
    logic [OPC_NUM-1:0] opc;
    logic [4:0]         alu_op;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [31:0]        imm;
    logic               illegal;
  } decoded_t;

endpackage

// File: rtl/inst_decode_comb.sv
// Pure combinational RV32 decoder: raw instruction to decoded_t record.
// M-extension legality follows INST_DECODE_MEXT_EN through decode_pkg::MEXT_EN.
module inst_decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output decoded_t    dec
);

  logic [6:0]         f7;
  logic [2:0]         f3;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [OPC_NUM-1:0] opc;
  logic               illegal;
  logic               is_env;
  logic [31:0]        imm;
  logic [31:0]        imm_i;
  logic [31:0]        imm_s;
  logic [31:0]        imm_b;
  logic [31:0]        imm_u;
  logic [31:0]        imm_j;

  assign f7  = inst[31:25];
  assign f3  = inst[14:12];
  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // ECALL / EBREAK only; MRET, WFI and friends fall through as illegal
  assign is_env = (f3 == 3'd0) && (rd == 5'd0) && (rs1 == 5'd0) && (inst[31:21] == 11'd0);

  always_comb begin
    opc = '0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        OPV_LOAD:    opc[OPC_LOAD]    = 1'b1;
        OPV_MISCMEM: opc[OPC_MISCMEM] = 1'b1;
        OPV_OPIMM:   opc[OPC_OPIMM]   = 1'b1;
        OPV_AUIPC:   opc[OPC_AUIPC]   = 1'b1;
        OPV_STORE:   opc[OPC_STORE]   = 1'b1;
        OPV_OP:      opc[OPC_OP]      = 1'b1;
        OPV_LUI:     opc[OPC_LUI]     = 1'b1;
        OPV_BRANCH:  opc[OPC_BRANCH]  = 1'b1;
        OPV_JALR:    opc[OPC_JALR]    = 1'b1;
        OPV_JAL:     opc[OPC_JAL]     = 1'b1;
        OPV_SYSTEM:  opc[OPC_SYSTEM]  = 1'b1;
        default:     opc = '0;
      endcase
    end
  end

  always_comb begin
    illegal = (opc == '0);
    if (opc[OPC_JALR] && (f3 != 3'd0))        illegal = 1'b1;
    if (opc[OPC_BRANCH] && !BRANCH_F3_OK[f3]) illegal = 1'b1;
    if (opc[OPC_LOAD] && !LOAD_F3_OK[f3])     illegal = 1'b1;
    if (opc[OPC_STORE] && !STORE_F3_OK[f3])   illegal = 1'b1;
    if (opc[OPC_MISCMEM] && (f3 != 3'd0))     illegal = 1'b1;
    if (opc[OPC_OP]) begin
      case (f7)
        F7_ZERO:   illegal = illegal;
        F7_ALT:    if ((f3 != 3'd0) && (f3 != 3'd5)) illegal = 1'b1;
        F7_MULDIV: if (!MEXT_EN) illegal = 1'b1;
        default:   illegal = 1'b1;
      endcase
    end
    if (opc[OPC_OPIMM] && ((f3 == 3'd1) || (f3 == 3'd5)) &&
        !((f7 == F7_ZERO) || ((f7 == F7_ALT) && (f3 == 3'd5))))
      illegal = 1'b1;
    if (opc[OPC_SYSTEM] && !(is_env || CSR_F3_OK[f3])) illegal = 1'b1;
  end

  always_comb begin
    imm = '0;
    if (opc[OPC_LUI] || opc[OPC_AUIPC])  imm = imm_u;
    else if (opc[OPC_JAL])               imm = imm_j;
    else if (opc[OPC_BRANCH])            imm = imm_b;
    else if (opc[OPC_STORE])             imm = imm_s;
    else if (opc[OPC_JALR] || opc[OPC_LOAD] || opc[OPC_OPIMM] ||
             opc[OPC_MISCMEM] || opc[OPC_SYSTEM])
      imm = imm_i;
  end

  always_comb begin
    dec         = '0;
    dec.opc     = opc;
    dec.alu_op  = {f7[0] & MEXT_EN, f7[5], f3};
    dec.rd      = rd;
    dec.rs1     = rs1;
    dec.rs2     = inst[24:20];
    dec.imm     = imm;
    dec.illegal = illegal;
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered RV32 decode stage: decodes accepted instructions into a DEPTH-entry in-order queue
// and stops accepting after an illegal instruction until flush. M extension via INST_DECODE_MEXT_EN.
module inst_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_inst,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  output logic [10:0]                out_opc,
  output logic [4:0]                 out_alu_op,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {RUN, TRAP} state_e;

  state_e          state_q;
  state_e          state_d;
  decoded_t        dec;
  decoded_t        rec_q  [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] inst_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  inst_decode_comb u_decode (
    .inst (in_inst),
    .dec  (dec)
  );

  // A full queue still accepts when the head leaves in the same cycle
  assign in_ready  = (state_q == RUN) && ((count < FULL_CNT) || out_ready);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage is cleared on reset so every out_* field reads zero afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rec_q[i]  <= '0;
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (push) begin
      rec_q[wr_ptr]  <= dec;
      pc_q[wr_ptr]   <= in_pc;
      inst_q[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                     state_d = RUN;
    else if (push && dec.illegal)  state_d = TRAP;
  end

  assign out_pc      = pc_q[rd_ptr];
  assign out_inst    = inst_q[rd_ptr];
  assign out_opc     = rec_q[rd_ptr].opc;
  assign out_alu_op  = rec_q[rd_ptr].alu_op;
  assign out_rd      = rec_q[rd_ptr].rd;
  assign out_rs1     = rec_q[rd_ptr].rs1;
  assign out_rs2     = rec_q[rd_ptr].rs2;
  assign out_imm     = rec_q[rd_ptr].imm;
  assign out_illegal = rec_q[rd_ptr].illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Scoreboard bench for inst_decode_stage: directed vectors with hand-decoded expected records.
// Expectations for MUL follow INST_DECODE_MEXT_EN.
module tb_inst_decode_stage;

`ifdef INST_DECODE_MEXT_EN
  localparam logic MX = 1'b1;
`else
  localparam logic MX = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [10:0] opc;
    logic [4:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [10:0] out_opc;
  logic [4:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [1:0]  count;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  exp_t mexp;
  bit   acc;

  exp_t rAddi1, rAddi2, rAddi3, rLui, rSw, rBeq, rJal, rCsr, rZero, rMul, rAddi4;

  inst_decode_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_opc     (out_opc),
    .out_alu_op  (out_alu_op),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [10:0] opc,
                              input logic [4:0] alu, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic ill);
    exp_t e;
    e.pc = pc; e.inst = inst; e.opc = opc; e.alu = alu; e.rd = rd;
    e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one instruction for one cycle; the expected record is queued only if it was taken
  task automatic applyStimulus(input exp_t e, output bit accepted);
    in_valid = 1'b1;
    in_pc    = e.pc;
    in_inst  = e.inst;
    @(negedge clk);
    accepted = in_ready && !flush && !rst;
    if (accepted) expQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && (expQ.size() != 0 || out_valid); i++) step(1);
    checkOutput("drain_sb_empty", expQ.size(), 32'd0);
    checkOutput("drain_count", 32'(count), 32'd0);
  endtask

  // Monitor: every real pop is compared against the oldest expected record
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL mon_unexpected: got record pc 0x%0h expected none", out_pc);
      end else begin
        mexp = expQ.pop_front();
        checkOutput("mon_pc", out_pc, mexp.pc);
        checkOutput("mon_inst", out_inst, mexp.inst);
        checkOutput("mon_opc", 32'(out_opc), 32'(mexp.opc));
        checkOutput("mon_alu_op", 32'(out_alu_op), 32'(mexp.alu));
        checkOutput("mon_rd", 32'(out_rd), 32'(mexp.rd));
        checkOutput("mon_rs1", 32'(out_rs1), 32'(mexp.rs1));
        checkOutput("mon_rs2", 32'(out_rs2), 32'(mexp.rs2));
        checkOutput("mon_imm", out_imm, mexp.imm);
        checkOutput("mon_illegal", 32'(out_illegal), 32'(mexp.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;

    rAddi1 = mk(32'h100, 32'h00500093, 11'h004, 5'b00000, 5'd1,  5'd0, 5'd5,  32'd5,        1'b0);
    rAddi2 = mk(32'h104, 32'h00700113, 11'h004, 5'b00000, 5'd2,  5'd0, 5'd7,  32'd7,        1'b0);
    rAddi3 = mk(32'h108, 32'h04000193, 11'h004, 5'b00000, 5'd3,  5'd0, 5'd0,  32'h40,       1'b0);
    rLui   = mk(32'h10C, 32'h800002B7, 11'h040, 5'b00000, 5'd5,  5'd0, 5'd0,  32'h80000000, 1'b0);
    rSw    = mk(32'h110, 32'h0020A423, 11'h010, 5'b00010, 5'd8,  5'd1, 5'd2,  32'd8,        1'b0);
    rBeq   = mk(32'h114, 32'hFE208EE3, 11'h080, {MX, 4'b1000}, 5'd29, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
    rJal   = mk(32'h118, 32'h010000EF, 11'h200, 5'b00000, 5'd1,  5'd0, 5'd16, 32'd16,       1'b0);
    rCsr   = mk(32'h11C, 32'h300022F3, 11'h400, 5'b00010, 5'd5,  5'd0, 5'd0,  32'h300,      1'b0);
    rZero  = mk(32'h120, 32'h00000000, 11'h000, 5'b00000, 5'd0,  5'd0, 5'd0,  32'd0,        1'b1);
    rMul   = mk(32'h130, 32'h02208033, 11'h020, {MX, 4'b0000}, 5'd0, 5'd1, 5'd2, 32'd0,      ~MX);
    rAddi4 = mk(32'h200, 32'h00500093, 11'h004, 5'b00000, 5'd1,  5'd0, 5'd5,  32'd5,        1'b0);

    #2 rst = 1'b1;
    step(2);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_inst", out_inst, 32'd0);
    checkOutput("rst_out_opc", 32'(out_opc), 32'd0);
    checkOutput("rst_out_imm", out_imm, 32'd0);
    rst = 1'b0;
    step(1);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] single ADDI with out_ready high");
    out_ready = 1'b1;
    applyStimulus(rAddi1, acc);
    checkOutput("addi_accept", 32'(acc), 32'd1);
    checkOutput("addi_latency_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_latency_pc", out_pc, 32'h100);
    step(1);
    checkOutput("addi_popped_count", 32'(count), 32'd0);

    $display("[TB] fill with out_ready low");
    out_ready = 1'b0;
    applyStimulus(rAddi2, acc);
    checkOutput("fill_accept0", 32'(acc), 32'd1);
    applyStimulus(rAddi3, acc);
    checkOutput("fill_accept1", 32'(acc), 32'd1);
    applyStimulus(rLui, acc);
    checkOutput("fill_blocked", 32'(acc), 32'd0);
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    checkOutput("fill_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    #1;
    checkOutput("full_ready_follows_out_ready", 32'(in_ready), 32'd1);

    $display("[TB] full queue streaming with simultaneous pop");
    applyStimulus(rLui, acc);
    checkOutput("stream_accept_lui", 32'(acc), 32'd1);
    checkOutput("stream_count_lui", 32'(count), 32'd2);
    applyStimulus(rSw, acc);
    checkOutput("stream_accept_sw", 32'(acc), 32'd1);
    checkOutput("stream_count_sw", 32'(count), 32'd2);
    applyStimulus(rBeq, acc);
    checkOutput("stream_accept_beq", 32'(acc), 32'd1);
    checkOutput("stream_count_beq", 32'(count), 32'd2);
    applyStimulus(rJal, acc);
    checkOutput("stream_accept_jal", 32'(acc), 32'd1);
    checkOutput("stream_count_jal", 32'(count), 32'd2);
    waitDrain();

    $display("[TB] illegal instruction traps the stage");
    out_ready = 1'b0;
    applyStimulus(rZero, acc);
    checkOutput("trap_accept_illegal", 32'(acc), 32'd1);
    applyStimulus(rAddi2, acc);
    checkOutput("trap_accept_after", 32'(acc), 32'd0);
    checkOutput("trap_in_ready", 32'(in_ready), 32'd0);
    checkOutput("trap_head_illegal", 32'(out_illegal), 32'd1);
    out_ready = 1'b1;
    step(1);
    checkOutput("trap_drained_valid", 32'(out_valid), 32'd0);
    checkOutput("trap_still_blocked", 32'(in_ready), 32'd0);
    flush = 1'b1; in_valid = 1'b1; in_inst = rAddi2.inst; in_pc = rAddi2.pc;
    expQ.delete();
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush_count", 32'(count), 32'd0);

    $display("[TB] MUL and CSRRS");
    applyStimulus(rMul, acc);
    checkOutput("mul_accept", 32'(acc), 32'd1);
    waitDrain();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    applyStimulus(rCsr, acc);
    checkOutput("csr_accept", 32'(acc), 32'd1);
    waitDrain();
    checkOutput("csr_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] flush drops queued records and same-cycle input");
    out_ready = 1'b0;
    applyStimulus(rAddi2, acc);
    applyStimulus(rAddi3, acc);
    checkOutput("pre_flush_count", 32'(count), 32'd2);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_inst = rJal.inst; in_pc = rJal.pc;
    expQ.delete();
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("post_flush_count", 32'(count), 32'd0);
    checkOutput("post_flush_valid", 32'(out_valid), 32'd0);
    checkOutput("post_flush_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] asynchronous reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(rAddi2, acc);
    applyStimulus(rJal, acc);
    checkOutput("pre_rst_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_pc", out_pc, 32'd0);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1);
    out_ready = 1'b1;
    applyStimulus(rAddi4, acc);
    checkOutput("after_rst_accept", 32'(acc), 32'd1);
    checkOutput("after_rst_valid", 32'(out_valid), 32'd1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
